// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants for the multiply/divide unit
package mips_pkg;

   // operation select presented with start
   localparam logic [1:0] MD_MULT  = 2'd0;
   localparam logic [1:0] MD_MULTU = 2'd1;
   localparam logic [1:0] MD_DIV   = 2'd2;
   localparam logic [1:0] MD_DIVU  = 2'd3;

   // R-type funct codes decoded by the control unit into start/op
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/result bundle between pipeline and multiply/divide unit
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             rd_hi;
   logic             rd_lo;
   logic             busy;
   logic             done;
   logic             stall;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_val, rt_val, rd_hi, rd_lo,
      input  busy, done, stall, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val, rd_hi, rd_lo,
      output busy, done, stall, hi, lo
   );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add multiply or restoring divide iteration
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] acc_next
);
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_diff;

   // multiply: conditionally add multiplicand to upper half, shift right with carry;
   // divide: shift remainder:quotient left, subtract divisor when it fits
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      rem_diff = rem_sh[WIDTH-1:0] - opnd;
      acc_next = {mul_sum, acc[WIDTH-1:1]};
      if (is_div) begin
         if (rem_sh >= {1'b0, opnd}) begin
            acc_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
module muldiv_sequencer
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic               clk,
   input logic               rst,
   muldiv_sequencer_if.slave md
);
   md_state_t          state, state_nxt;
   logic               is_div_q, div_zero_q, neg_q_q, neg_r_q, done_q;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc, acc_step;
   logic [WIDTH-1:0]   opnd, rs_raw, hi_q, lo_q, fix_hi, fix_lo;
   logic               rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_mag, rt_mag;

   // the core iterates on magnitudes; signs are restored in FIX
   assign rs_neg = op_is_signed(md.op) & md.rs_val[WIDTH-1];
   assign rt_neg = op_is_signed(md.op) & md.rt_val[WIDTH-1];
   assign rs_mag = rs_neg ? -md.rs_val : md.rs_val;
   assign rt_mag = rt_neg ? -md.rt_val : md.rt_val;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (is_div_q),
      .acc      (acc),
      .opnd     (opnd),
      .acc_next (acc_step)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_nxt;
   end

   // next state: WIDTH RUN cycles then one FIX cycle
   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (md.start) state_nxt = MD_RUN;
         MD_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = MD_FIX;
         MD_FIX:  state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   // sign correction and divide-by-zero override applied to the final magnitudes
   always_comb begin
      fix_hi = acc[2*WIDTH-1:WIDTH];
      fix_lo = acc[WIDTH-1:0];
      if (!is_div_q) begin
         if (neg_q_q) {fix_hi, fix_lo} = -acc;
      end else if (div_zero_q) begin
         fix_hi = rs_raw;
         fix_lo = '1;
      end else begin
         if (neg_q_q) fix_lo = -acc[WIDTH-1:0];
         if (neg_r_q) fix_hi = -acc[2*WIDTH-1:WIDTH];
      end
   end

   // operand latch, iteration datapath and HI/LO write-back
   always_ff @(posedge clk) begin
      if (rst) begin
         is_div_q   <= 1'b0;
         div_zero_q <= 1'b0;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         done_q     <= 1'b0;
         cnt        <= '0;
         acc        <= '0;
         opnd       <= '0;
         rs_raw     <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         done_q <= (state == MD_FIX);
         case (state)
            MD_IDLE: begin
               if (md.start) begin
                  is_div_q   <= op_is_div(md.op);
                  div_zero_q <= (md.rt_val == '0);
                  neg_q_q    <= rs_neg ^ rt_neg;
                  neg_r_q    <= rs_neg;
                  rs_raw     <= md.rs_val;
                  cnt        <= '0;
                  acc        <= {{WIDTH{1'b0}}, rs_mag};
                  opnd       <= rt_mag;
               end
            end
            MD_RUN: begin
               acc <= acc_step;
               cnt <= cnt + 1'b1;
            end
            MD_FIX: begin
               hi_q <= fix_hi;
               lo_q <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign md.busy  = (state != MD_IDLE);
   assign md.done  = done_q;
   assign md.stall = md.busy & (md.start | md.rd_hi | md.rd_lo);
   assign md.hi    = hi_q;
   assign md.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(W)) md ();

   muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .md  (md)
   );

   // architectural result of one operation, from plain arithmetic
   function automatic void ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
      longint sa, sb;
      logic [63:0] p;
      int ia, ib;
      h = '0;
      l = '0;
      case (op)
         2'd0: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
            {h, l} = p;
         end
         2'd1: begin
            p = {32'b0, a} * {32'b0, b};
            {h, l} = p;
         end
         2'd2: begin
            ia = a;
            ib = b;
            if (b == 0) begin
               h = a; l = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               h = 32'h0; l = 32'h8000_0000;
            end else begin
               l = ia / ib;
               h = ia % ib;
            end
         end
         default: begin
            if (b == 0) begin
               h = a; l = 32'hFFFF_FFFF;
            end else begin
               l = a / b;
               h = a % b;
            end
         end
      endcase
   endfunction

   // issue one op and wait for done; lat = edges from start sample to done, -1 on timeout
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output int lat, output int busy_cnt);
      int k;
      @(negedge clk);
      md.start = 1'b1; md.op = op; md.rs_val = a; md.rt_val = b;
      @(negedge clk);
      md.start = 1'b0; md.op = 2'($urandom); md.rs_val = $urandom; md.rt_val = $urandom;
      k = 0; lat = -1; busy_cnt = 0;
      while (lat < 0 && k < 200) begin
         if (md.done) lat = k;
         else begin
            if (md.busy) busy_cnt++;
            @(negedge clk);
            k++;
         end
      end
      h = md.hi;
      l = md.lo;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (md.hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got=%h exp=0", md.hi); end
      n_cmp++; if (md.lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got=%h exp=0", md.lo); end
      n_cmp++; if (md.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", md.busy); end
      n_cmp++; if (md.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", md.done); end
      n_cmp++; if (md.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", md.stall); end
      md.rd_hi = 1'b1;
      #1;
      n_cmp++; if (md.stall !== 1'b0) begin n_bad++; $display("FAIL mfhi_idle_stall got=%b exp=0", md.stall); end
      n_cmp++; if (md.hi !== 32'h0) begin n_bad++; $display("FAIL mfhi_idle_val got=%h exp=0", md.hi); end
      md.rd_hi = 1'b0;
   endtask

   task automatic check_case(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eh, input logic [31:0] el);
      logic [31:0] h, l;
      int lat, bc;
      do_op(op, a, b, h, l, lat, bc);
      n_cmp++; if (lat !== W + 1) begin n_bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, W + 1); end
      n_cmp++; if (bc !== W + 1) begin n_bad++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bc, W + 1); end
      n_cmp++; if (h !== eh) begin n_bad++; $display("FAIL %s_hi got=%h exp=%h", name, h, eh); end
      n_cmp++; if (l !== el) begin n_bad++; $display("FAIL %s_lo got=%h exp=%h", name, l, el); end
   endtask

   task automatic test_directed();
      check_case("mult_7_m3",   2'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      check_case("divu_100_7",  2'd3, 32'd100,        32'd7,         32'd2,         32'd14);
      check_case("div_m7_2",    2'd2, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      check_case("div_ovf",     2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
      check_case("divu_5_0",    2'd3, 32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF);
      check_case("div_m9_0",    2'd2, 32'hFFFF_FFF7,  32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF);
   endtask

   task automatic test_random();
      logic [31:0] a, b, h, l, eh, el;
      logic [1:0]  op;
      int lat, bc;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
            2: a = 32'h8000_0000;
            3: b = -($urandom_range(1, 9));
            default: ;
         endcase
         ref_md(op, a, b, eh, el);
         do_op(op, a, b, h, l, lat, bc);
         n_cmp++; if (lat !== W + 1) begin n_bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, W + 1); end
         n_cmp++; if (h !== eh) begin n_bad++; $display("FAIL rand%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, h, eh); end
         n_cmp++; if (l !== el) begin n_bad++; $display("FAIL rand%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, l, el); end
      end
   endtask

   task automatic test_stall_ignore();
      int k;
      logic seen;
      @(negedge clk);
      md.start = 1'b1; md.op = 2'd1; md.rs_val = 32'd3; md.rt_val = 32'd4;
      @(negedge clk);
      md.start = 1'b0;
      repeat (4) @(negedge clk);
      md.start = 1'b1; md.op = 2'd3; md.rs_val = 32'd100; md.rt_val = 32'd7; md.rd_lo = 1'b1;
      #1;
      k = 0; seen = 1'b0;
      while (!seen && k < 100) begin
         if (md.done) seen = 1'b1;
         else begin
            n_cmp++; if (md.stall !== 1'b1) begin n_bad++; $display("FAIL stall_hold k=%0d got=%b exp=1", k, md.stall); end
            @(negedge clk);
            #1;
            k++;
         end
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL stall_done_timeout got=none exp=done"); end
      n_cmp++; if (md.stall !== 1'b0) begin n_bad++; $display("FAIL stall_done_cycle got=%b exp=0", md.stall); end
      n_cmp++; if (md.lo !== 32'd12) begin n_bad++; $display("FAIL stall_lo got=%h exp=c", md.lo); end
      n_cmp++; if (md.hi !== 32'd0) begin n_bad++; $display("FAIL stall_hi got=%h exp=0", md.hi); end
      md.start = 1'b0; md.rd_lo = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++; if (md.busy !== 1'b0) begin n_bad++; $display("FAIL ignored_start_busy got=%b exp=0", md.busy); end
      n_cmp++; if (md.lo !== 32'd12) begin n_bad++; $display("FAIL hold_lo got=%h exp=c", md.lo); end
   endtask

   task automatic test_reset_abort();
      int dn;
      @(negedge clk);
      md.start = 1'b1; md.op = 2'd2; md.rs_val = 32'd1000; md.rt_val = 32'd3;
      @(negedge clk);
      md.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (md.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", md.busy); end
      n_cmp++; if (md.hi !== 32'h0) begin n_bad++; $display("FAIL abort_hi got=%h exp=0", md.hi); end
      n_cmp++; if (md.lo !== 32'h0) begin n_bad++; $display("FAIL abort_lo got=%h exp=0", md.lo); end
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (md.done) dn++;
      end
      n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
      n_cmp++; if (md.lo !== 32'h0) begin n_bad++; $display("FAIL abort_lo_after got=%h exp=0", md.lo); end
   endtask

   initial begin
      md.start = 1'b0; md.op = 2'd0; md.rs_val = '0; md.rt_val = '0;
      md.rd_hi = 1'b0; md.rd_lo = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_stall_ignore();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
